// File: rtl/v2f_seq_udiv.sv
// v2f_seq_udiv: multi-cycle unsigned divider (restoring, radix-2).
// Produces one quotient bit per clock using only shift, subtract and compare.
//
// Handshake: an operation transfers on a rising pos_clk edge where
// in_valid && in_ready. A result transfers on an edge where
// out_valid && out_ready. in_ready and out_valid depend only on the
// state register, never on same-cycle inputs. q, r and dbz hold steady
// for as long as out_valid is high.
module v2f_seq_udiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             pos_clk,
  input  logic             pos_arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shift register, MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_q, quo_d;   // quotient, bits enter at the LSB
  logic [CNT_W-1:0] cnt_q, cnt_d;   // iterations left
  logic             dbz_q, dbz_d;

  // Restoring step. t is WIDTH+1 bits wide, so the compare stays unsigned
  // and correct even when the remainder already has its top bit set.
  logic [WIDTH:0] t_w;
  logic [WIDTH:0] sub_w;
  logic           ge_w;

  assign t_w   = {rem_q, dvd_q[WIDTH-1]};
  assign ge_w  = (t_w >= {1'b0, dvs_q});
  assign sub_w = t_w - {1'b0, dvs_q};

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign q           = quo_q;
  assign r           = rem_q;
  assign dbz         = dbz_q;
  assign dbg_state_o = state_q;

  // State and datapath registers; asynchronous reset to all-zero / IDLE.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update: accept, iterate, then hold the result.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d = a;
          dvs_d = b;
          cnt_d = CNT_INIT;
          if (b == '0) begin
            // Divide by zero short-circuits straight to the result.
            quo_d   = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (ge_w) begin
          rem_d = sub_w[WIDTH-1:0];
        end else begin
          rem_d = t_w[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ge_w};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_v2f_seq_udiv.sv
// tb_v2f_seq_udiv: directed and randomized checks of v2f_seq_udiv at
// WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_v2f_seq_udiv;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT WIDTH=32 ----------------
  logic        in_valid32 = 1'b0, out_ready32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, dbz32;
  logic [31:0] q32, r32;
  logic [1:0]  st32;

  v2f_seq_udiv #(.WIDTH(32)) u_dut32 (
    .pos_clk(clk), .pos_arst(arst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .q(q32), .r(r32), .dbz(dbz32),
    .dbg_state_o(st32)
  );

  // ---------------- DUT WIDTH=8 ----------------
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, dbz8;
  logic [7:0] q8, r8;
  logic [1:0] st8;

  v2f_seq_udiv #(.WIDTH(8)) u_dut8 (
    .pos_clk(clk), .pos_arst(arst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .q(q8), .r(r8), .dbz(dbz8),
    .dbg_state_o(st8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [64:0] exp32_q[$];   // {q, r, dbz}
  logic [16:0] exp8_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain unsigned divide/modulo, all-ones quotient on b==0.
  function automatic logic [64:0] model32(input logic [31:0] ma, input logic [31:0] mb);
    if (mb == 0) return {32'hFFFF_FFFF, ma, 1'b1};
    return {ma / mb, ma % mb, 1'b0};
  endfunction

  function automatic logic [16:0] model8(input logic [7:0] ma, input logic [7:0] mb);
    if (mb == 0) return {8'hFF, ma, 1'b1};
    return {ma / mb, ma % mb, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // Directed op on the 32-bit DUT. Called #1 after a rising edge in IDLE.
  task automatic do_op32(input logic [31:0] ta, input logic [31:0] tb_v,
                         input int hold, input bit toggle, input string tag);
    logic [64:0] e;
    int edges;
    int exp_lat;
    e = model32(ta, tb_v);
    exp_lat = (tb_v == 0) ? 1 : 33;
    chk({tag, "_in_ready"}, in_ready32, 1);
    a32 = ta; b32 = tb_v; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    edges = 1;
    while (!out_valid32 && edges < 100) begin
      if (toggle) begin
        a32 = $urandom; b32 = $urandom; in_valid32 = $urandom_range(0, 1);
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid32 = 1'b0;
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_result"}, {q32, r32, dbz32}, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {out_valid32, in_ready32, q32, r32, dbz32}, {2'b10, e});
    end
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    chk({tag, "_release"}, {in_ready32, out_valid32, dbz32}, 3'b100);
  endtask

  // Random back-to-back traffic on the 32-bit DUT with random backpressure.
  // Inputs change on the falling edge; the handshake that the next rising
  // edge will perform is decided from the values set here.
  task automatic rand32(input int nops);
    int issued = 0;
    int cyc = 0;
    bit pend = 0;
    logic [64:0] e;
    logic [31:0] ra, rb;
    while ((issued < nops || exp32_q.size() > 0) && cyc < 40000) begin
      @(negedge clk); cyc++;
      out_ready32 = ($urandom_range(0, 3) != 0);
      if (!pend) in_valid32 = 1'b0;
      if (!pend && issued < nops && $urandom_range(0, 3) != 0) begin
        ra = $urandom; rb = $urandom;
        case ($urandom_range(0, 7))
          0: rb = 0;
          1: rb = 1;
          2: rb = $urandom_range(2, 15);
          3: ra = rb;
          4: ra = $urandom_range(0, 255);
          5: begin rb = 32'h8000_0000 | rb; ra = 32'hFFFF_FFFF - $urandom_range(0, 3); end
          default: ;
        endcase
        a32 = ra; b32 = rb; in_valid32 = 1'b1; pend = 1;
      end
      if (in_valid32 && in_ready32) begin
        exp32_q.push_back(model32(a32, b32));
        issued++;
        pend = 0;
      end
      if (out_valid32 && out_ready32) begin
        if (exp32_q.size() == 0) chk("rand32_extra_result", 1, 0);
        else begin
          e = exp32_q.pop_front();
          chk("rand32_result", {q32, r32, dbz32}, e);
        end
      end
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0; out_ready32 = 1'b0;
    chk("rand32_drain", {issued, exp32_q.size()}, {nops, 0});
  endtask

  // Same traffic pattern on the 8-bit DUT.
  task automatic rand8(input int nops);
    int issued = 0;
    int cyc = 0;
    bit pend = 0;
    logic [16:0] e;
    logic [7:0] ra, rb;
    while ((issued < nops || exp8_q.size() > 0) && cyc < 40000) begin
      @(negedge clk); cyc++;
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (!pend) in_valid8 = 1'b0;
      if (!pend && issued < nops && $urandom_range(0, 3) != 0) begin
        ra = 8'($urandom); rb = 8'($urandom);
        case ($urandom_range(0, 6))
          0: rb = 0;
          1: rb = 1;
          2: ra = rb;
          3: begin rb = 8'h80 | rb; ra = 8'hFF; end
          default: ;
        endcase
        a8 = ra; b8 = rb; in_valid8 = 1'b1; pend = 1;
      end
      if (in_valid8 && in_ready8) begin
        exp8_q.push_back(model8(a8, b8));
        issued++;
        pend = 0;
      end
      if (out_valid8 && out_ready8) begin
        if (exp8_q.size() == 0) chk("rand8_extra_result", 1, 0);
        else begin
          e = exp8_q.pop_front();
          chk("rand8_result", {q8, r8, dbz8}, e);
        end
      end
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    chk("rand8_drain", {issued, exp8_q.size()}, {nops, 0});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    chk("reset32", {in_ready32, out_valid32, q32, r32, dbz32}, {2'b10, 65'd0});
    chk("reset8", {in_ready8, out_valid8, q8, r8, dbz8}, {2'b10, 17'd0});
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk); #1;

    do_op32(32'd100, 32'd7, 0, 0, "basic");
    do_op32(32'hFFFF_FFFF, 32'h8000_0000, 0, 0, "msb_guard");
    do_op32(32'd1234, 32'd0, 0, 0, "div_zero");
    do_op32(32'd50, 32'd3, 10, 1, "backpressure");
    do_op32(32'd5, 32'd9, 0, 0, "a_lt_b");
    do_op32(32'd77, 32'd77, 0, 0, "a_eq_b");
    do_op32(32'hDEAD_BEEF, 32'd1, 0, 0, "b_one");
    do_op32(32'd0, 32'd5, 0, 0, "a_zero");
    do_op32(32'h8000_0001, 32'hFFFF_FFFF, 0, 0, "b_max");

    // Reset during CALC discards the operation.
    a32 = 32'd9999; b32 = 32'd13; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (4) @(posedge clk);
    #1 arst = 1'b1;
    #1;
    chk("mid_reset", {out_valid32, in_ready32, q32, r32, dbz32}, {2'b01, 65'd0});
    @(posedge clk); #1;
    arst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid32) chk("mid_reset_no_out", out_valid32, 0);
    end
    chk("mid_reset_idle", {in_ready32, out_valid32}, 2'b10);
    do_op32(32'd9, 32'd3, 0, 0, "after_reset");

    rand32(200);
    rand8(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
